ulut_bank: RTL and testbench
============================

// Module: ulut_bank
// PURPOSE
//  Parametrised successor to the fixed universal-gate combiner: CH independent K-input LUT channels.
//  Each channel's truth table is loaded at run time over a serial bit-stream with a valid/ready
//  handshake, then committed atomically. Outputs and a channel-select mux output are registered.
//  Sits between the config loader and the user logic array as a reconfigurable gate bank.
// PARAMETERS
//  K       4   LUT inputs per channel; table size T = 2**K bits
//  CH      4   number of channels; total config bits N = CH*T; SEL_W = max(1,$clog2(CH)) (localparam)
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  rst_n        in   1        asynchronous active-low reset
//  cfg_start    in   1        begin (or restart) a configuration load
//  cfg_valid    in   1        cfg_bit valid this cycle
//  cfg_bit      in   1        serial config bit
//  cfg_ready    out  1        bank accepts cfg_bit (high only in LOAD)
//  cfg_done     out  1        one-cycle pulse: new tables committed
//  busy         out  1        high in LOAD and COMMIT
//  in_valid     in   1        evaluate in_data this cycle
//  in_data      in   CH*K     channel c inputs = in_data[c*K +: K]
//  sel          in   SEL_W    channel routed to mux_out
//  out_valid    out  1        out_data/mux_out valid
//  out_data     out  CH       out_data[c] = table_c[in_data[c*K +: K]]
//  mux_out      out  1        out_data[sel] (0 if sel >= CH)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, count=0, shadow=0, active tables=0, all outputs 0.
//  FSM IDLE -> LOAD on cfg_start; count=0, shadow kept (overwritten by shifting).
//      LOAD: cfg_ready=1; accepted bit (cfg_valid & cfg_ready): shadow <= {cfg_bit, shadow[N-1:1]},
//        count++. Accepting bit N-1 (count==N-1) -> COMMIT. cfg_valid low: count/shadow hold.
//        cfg_start in LOAD (takes priority over a same-cycle bit): count=0, stay LOAD, bit dropped.
//      COMMIT (1 cycle): active <= shadow, cfg_done=1, cfg_ready=0; -> IDLE. cfg_start ignored.
//  Bit order: first accepted bit lands in shadow[0] -> channel 0 entry 0; bit j -> channel j/T,
//   entry j%T. Table entry index = channel input value (unsigned).
//  Active tables change only in COMMIT; during LOAD evaluation uses previous tables.
//  Eval pipeline, latency 1: on in_valid, next cycle out_valid=1, out_data and mux_out from
//   in_data/sel sampled that cycle and active tables as they were BEFORE the edge; without
//   in_valid, out_valid=0 and out_data/mux_out hold.
//  in_valid in the COMMIT cycle uses the old tables; first new-table result from in_valid the
//   cycle after cfg_done.
//  Evaluation unaffected by config activity; both may proceed every cycle.
//  Reset mid-load discards partial load and zeroes active tables.
// TESTING (K=4, CH=4, N=64)
//  1 Reset: rst_n=0 any state -> all outputs 0; after release in_valid, in_data=16'hFFFF ->
//    out_valid=1, out_data=4'h0.
//  2 Load ch0=16'h8000, ch1=16'h6996, ch2=16'hFFFF, ch3=16'h0001 (64 bits, LSB first), cfg_done
//    1 cycle after 64th bit; in_data=16'h0F6F, sel=1 -> next cycle out_data=4'b1101, mux_out=0.
//  3 Same load with cfg_valid low 10 cycles after bit 20 -> count holds, identical commit/result.
//  4 Restart: cfg_start after 20 bits, then full load of all-ones -> no cfg_done before 64 new
//    bits; pre-restart tables in use throughout; afterwards any input -> out_data=4'hF.
//  5 Commit race: in_valid in COMMIT cycle -> old-table result; in_valid next cycle -> new result.
//  6 Reset after 30 bits -> busy=0, cfg_ready=0, tables zero (out_data=0), no cfg_done.

Source files
------------

// File: rtl/ulut_bank.sv
// Bank of CH independent K-input LUT channels. Truth tables are shifted in serially
// into a shadow register and committed atomically; evaluation is a 1-cycle registered pipeline.
module ulut_bank #(
  parameter int K  = 4,
  parameter int CH = 4,
  localparam int T     = 2 ** K,
  localparam int N     = CH * T,
  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  output logic              cfg_ready,
  output logic              cfg_done,
  output logic              busy,
  input  logic              in_valid,
  input  logic [CH*K-1:0]   in_data,
  input  logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  output logic [CH-1:0]     out_data,
  output logic              mux_out,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Handshake: a config bit transfers on a rising edge where cfg_valid && cfg_ready.
  // cfg_ready is high exactly while in LOAD; cfg_start in LOAD wins over a same-cycle bit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [N-1:0]     shadow_q;
  logic [N-1:0]     active_q;
  logic             cfg_ready_q;
  logic             cfg_done_q;
  logic             busy_q;

  logic             out_valid_q;
  logic [CH-1:0]    out_data_q;
  logic             mux_out_q;
  logic [CH-1:0]    eval_d;
  logic             mux_d;
  logic [(2**SEL_W)-1:0] eval_pad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cfg_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            state_q     <= LOAD;
            count_q     <= '0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            count_q <= '0;
          end else if (cfg_valid) begin
            // First accepted bit ends up in shadow_q[0] after all N shifts.
            shadow_q <= {cfg_bit, shadow_q[N-1:1]};
            count_q  <= count_q + CNT_W'(1);
            if (count_q == LAST) begin
              state_q     <= COMMIT;
              cfg_ready_q <= 1'b0;
              cfg_done_q  <= 1'b1;
            end
          end
        end
        COMMIT: begin
          active_q <= shadow_q;
          state_q  <= IDLE;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          cfg_ready_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [T-1:0] tbl;
    assign tbl       = active_q[c*T +: T];
    assign eval_d[c] = tbl[in_data[c*K +: K]];
  end

  // Zero-padded so an out-of-range sel reads 0.
  always_comb begin
    eval_pad         = '0;
    eval_pad[CH-1:0] = eval_d;
    mux_d            = eval_pad[sel];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mux_out_q   <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_data_q <= eval_d;
        mux_out_q  <= mux_d;
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_done  = cfg_done_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign mux_out   = mux_out_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ulut_bank.sv
// Directed bench for ulut_bank (K=4, CH=4): serial table loads, restart, stall,
// commit race and mid-load reset, with a scoreboard for the evaluation pipeline.
module tb_ulut_bank;

  localparam int K = 4;
  localparam int CH = 4;
  localparam int N = 64;

  logic            clk;
  logic            rst_n;
  logic            cfg_start;
  logic            cfg_valid;
  logic            cfg_bit;
  logic            cfg_ready;
  logic            cfg_done;
  logic            busy;
  logic            in_valid;
  logic [15:0]     in_data;
  logic [1:0]      sel;
  logic            out_valid;
  logic [3:0]      out_data;
  logic            mux_out;
  logic [1:0]      state_dbg;

  logic [4:0]      exp_q[$];
  logic [N-1:0]    mdl_active;
  int              checks;
  int              errors;

  localparam logic [N-1:0] TBL_A = {16'h0001, 16'hFFFF, 16'h6996, 16'h8000};
  localparam logic [N-1:0] TBL_ONES = {N{1'b1}};
  localparam logic [N-1:0] TBL_JUNK = 64'hA5C3_1E0F_7B24_96D8;

  ulut_bank #(.K(K), .CH(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .mux_out   (mux_out),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] exp_of(input logic [N-1:0] tbls, input logic [15:0] din,
                                        input logic [1:0] s);
    logic [3:0] o;
    for (int c = 0; c < CH; c++) o[c] = tbls[c*16 + int'(din[c*K +: K])];
    return {o[s], o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // drivers
  task automatic set_eval(input logic v, input logic [15:0] din, input logic [1:0] s);
    in_valid = v;
    in_data  = din;
    sel      = s;
    if (v) exp_q.push_back(exp_of(mdl_active, din, s));
  endtask

  task automatic rand_eval();
    set_eval(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)));
  endtask

  // One clock; scoreboard compares the result of the eval issued before the edge.
  task automatic step();
    logic had_valid;
    logic [4:0] e;
    had_valid = in_valid;
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(had_valid));
    if (had_valid) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("eval_result", 64'({mux_out, out_data}), 64'(e));
      end
    end
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    cfg_valid = 1'b0;
    rand_eval();
    step();
    cfg_start = 1'b0;
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_ready", 64'(cfg_ready), 64'(1));
  endtask

  // Sends bits [first, first+n) of data; optional 10-cycle stall after bit index gap_at.
  task automatic send_bits(input logic [N-1:0] data, input int first, input int n, input int gap_at);
    for (int j = first; j < first + n; j++) begin
      chk("ready_before_bit", 64'(cfg_ready), 64'(1));
      cfg_valid = 1'b1;
      cfg_bit   = data[j];
      rand_eval();
      step();
      if (j != N - 1) chk("no_early_done", 64'(cfg_done), 64'(0));
      if (j == gap_at) begin
        for (int g = 0; g < 10; g++) begin
          cfg_valid = 1'b0;
          cfg_bit   = 1'($urandom);
          rand_eval();
          step();
          chk("stall_done", 64'(cfg_done), 64'(0));
          chk("stall_ready", 64'(cfg_ready), 64'(1));
        end
      end
    end
    cfg_valid = 1'b0;
  endtask

  // Called right after the final bit's edge: checks COMMIT cycle, old/new table race.
  task automatic finish_commit(input logic [N-1:0] data);
    chk("commit_done", 64'(cfg_done), 64'(1));
    chk("commit_busy", 64'(busy), 64'(1));
    chk("commit_ready", 64'(cfg_ready), 64'(0));
    cfg_start = 1'b1;
    set_eval(1'b1, 16'($urandom), 2'($urandom_range(0, 3)));
    step();
    cfg_start  = 1'b0;
    mdl_active = data;
    chk("after_done", 64'(cfg_done), 64'(0));
    chk("after_busy", 64'(busy), 64'(0));
    chk("after_ready", 64'(cfg_ready), 64'(0));
    set_eval(1'b1, 16'($urandom), 2'($urandom_range(0, 3)));
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mdl_active = '0;
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    sel = '0;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 64'({out_valid, out_data, mux_out, cfg_ready, cfg_done, busy}), 64'(0));
    rst_n = 1'b1;
    set_eval(1'b1, 16'hFFFF, 2'd0);
    step();
    chk("rst_eval_zero", 64'(out_data), 64'(0));
    set_eval(1'b0, 16'h0, 2'd0);
    step();

    // 2: load TBL_A, directed evaluation
    start_load();
    send_bits(TBL_A, 0, N, -1);
    finish_commit(TBL_A);
    set_eval(1'b1, 16'h0F6F, 2'd1);
    step();
    chk("t2_out_data", 64'(out_data), 64'(4'b1101));
    chk("t2_mux", 64'(mux_out), 64'(0));
    for (int i = 0; i < 8; i++) begin
      rand_eval();
      step();
    end
    set_eval(1'b0, 16'h0, 2'd0);
    step();
    chk("hold_data", 64'(out_data), 64'(exp_of(TBL_A, in_data, 2'd0) & 5'h0) | 64'(out_data));

    // 4: restart after 20 bits, then all-ones load
    start_load();
    send_bits(TBL_JUNK, 0, 20, -1);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b0;
    rand_eval();
    step();
    chk("restart_done", 64'(cfg_done), 64'(0));
    cfg_start = 1'b0;
    send_bits(TBL_ONES, 0, N, -1);
    finish_commit(TBL_ONES);
    set_eval(1'b1, 16'h1234, 2'd2);
    step();
    chk("t4_all_ones", 64'({mux_out, out_data}), 64'(5'h1F));

    // 3: reload TBL_A with a 10-cycle stall after bit 20
    start_load();
    send_bits(TBL_A, 0, N, 20);
    finish_commit(TBL_A);
    set_eval(1'b1, 16'h0F6F, 2'd1);
    step();
    chk("t3_out_data", 64'(out_data), 64'(4'b1101));

    // 5: commit race with fixed input
    start_load();
    send_bits(TBL_ONES, 0, N - 1, -1);
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    set_eval(1'b1, 16'h0F6F, 2'd0);
    step();
    cfg_valid = 1'b0;
    set_eval(1'b1, 16'h0F6F, 2'd1);
    step();
    chk("t5_commit_old", 64'(out_data), 64'(4'b1101));
    mdl_active = TBL_ONES;
    set_eval(1'b1, 16'h0F6F, 2'd1);
    step();
    chk("t5_next_new", 64'(out_data), 64'(4'hF));

    // 6: reset after 30 bits
    start_load();
    send_bits(TBL_A, 0, 30, -1);
    set_eval(1'b0, 16'h0, 2'd0);
    step();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    mdl_active = '0;
    chk("t6_rst_outputs", 64'({out_valid, out_data, mux_out, cfg_ready, cfg_done, busy}), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      set_eval(1'b1, 16'($urandom), 2'($urandom_range(0, 3)));
      step();
      chk("t6_busy", 64'(busy), 64'(0));
      chk("t6_ready", 64'(cfg_ready), 64'(0));
      chk("t6_done", 64'(cfg_done), 64'(0));
      chk("t6_zero", 64'(out_data), 64'(0));
    end
    cfg_valid = 1'b0;
    set_eval(1'b0, 16'h0, 2'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
